mem_arbiter: RTL and testbench

- Shares one single-ported unified instruction/data memory between the IF stage (fetch) and the MEM stage (load/store).
- One transaction is in flight at a time. Data accesses have priority over fetch, and a starvation counter guarantees fetch progress.
- Generates byte enables and lane-replicated write data from funct3 and the address.
- Drives the stall signals back to the pipeline.

---
 rtl/mem_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch and data access.
// Optional cycle-level stall counters are enabled by defining MEM_ARB_PERF_EN.
module mem_arbiter #(
    parameter int unsigned FETCH_STARVE_LIMIT = 4,
    parameter int unsigned ADDR_W             = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [31:0]       if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [2:0]        dm_funct3,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [31:0]       dm_wdata,
    output logic              dm_done,
    output logic [31:0]       dm_rdata,
    output logic              dm_misalign,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata,
    output logic              stall_if,
`ifdef MEM_ARB_PERF_EN
    output logic              stall_mem,
    output logic [31:0]       perf_if_stall_cnt,
    output logic [31:0]       perf_dm_stall_cnt
`else
    output logic              stall_mem
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_D = 2'd1,
        SERVE_I = 2'd2
    } state_t;

    localparam logic [3:0]        STARVE_LIMIT = 4'(FETCH_STARVE_LIMIT);
    localparam logic [ADDR_W-1:0] WORD_MASK    = ~ADDR_W'(3);

    state_t      state, state_nxt;
    logic [3:0]  starve_cnt, starve_cnt_nxt;

    logic [3:0]  dm_be;
    logic [31:0] dm_wdata_rep;
    logic        dm_misaligned;

    // Size decode: funct3[2] only selects sign handling in the load unit.
    always_comb begin
        dm_be         = 4'b1111;
        dm_wdata_rep  = dm_wdata;
        dm_misaligned = 1'b0;
        case (dm_funct3)
            3'b000, 3'b100: begin
                dm_be        = 4'b0001 << dm_addr[1:0];
                dm_wdata_rep = {4{dm_wdata[7:0]}};
            end
            3'b001, 3'b101: begin
                dm_be         = 4'b0011 << dm_addr[1:0];
                dm_wdata_rep  = {2{dm_wdata[15:0]}};
                dm_misaligned = dm_addr[0];
            end
            default: dm_misaligned = |dm_addr[1:0];
        endcase
    end

    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        state_nxt      = state;
        starve_cnt_nxt = starve_cnt;
        if_done        = 1'b0;
        if_rdata       = '0;
        dm_done        = 1'b0;
        dm_rdata       = '0;
        dm_misalign    = 1'b0;
        mem_req        = 1'b0;
        mem_we         = 1'b0;
        mem_addr       = '0;
        mem_be         = '0;
        mem_wdata      = '0;
        case (state)
            IDLE: begin
                // Misaligned abort is combinational, so it must be masked while in reset.
                if (dm_req && dm_misaligned) begin
                    dm_done     = rst_n;
                    dm_misalign = rst_n;
                end else if (dm_req && (!if_req || (starve_cnt < STARVE_LIMIT))) begin
                    state_nxt = SERVE_D;
                    if (if_req) begin
                        starve_cnt_nxt = (starve_cnt == 4'hF) ? starve_cnt : starve_cnt + 4'd1;
                    end else begin
                        starve_cnt_nxt = '0;
                    end
                end else if (if_req) begin
                    state_nxt      = SERVE_I;
                    starve_cnt_nxt = '0;
                end
            end
            SERVE_D: begin
                mem_req   = 1'b1;
                mem_we    = dm_we;
                mem_addr  = dm_addr & WORD_MASK;
                mem_be    = dm_be;
                mem_wdata = dm_wdata_rep;
                if (mem_ready) begin
                    dm_done   = 1'b1;
                    dm_rdata  = mem_rdata;
                    state_nxt = IDLE;
                end
            end
            SERVE_I: begin
                mem_req  = 1'b1;
                mem_addr = if_addr & WORD_MASK;
                mem_be   = 4'b1111;
                if (mem_ready) begin
                    if_done   = 1'b1;
                    if_rdata  = mem_rdata;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            starve_cnt <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_cnt_nxt;
        end
    end

    assign stall_if  = if_req & ~if_done;
    assign stall_mem = dm_req & ~dm_done;

`ifdef MEM_ARB_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_if_stall_cnt <= '0;
            perf_dm_stall_cnt <= '0;
        end else begin
            if (stall_if && (perf_if_stall_cnt != '1)) begin
                perf_if_stall_cnt <= perf_if_stall_cnt + 32'd1;
            end
            if (stall_mem && (perf_dm_stall_cnt != '1)) begin
                perf_dm_stall_cnt <= perf_dm_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: inputs change on the falling edge,
// outputs are sampled 1 ns later, well away from the rising edge.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_rdata;
    logic        dm_req;
    logic        dm_we;
    logic [2:0]  dm_funct3;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_done;
    logic [31:0] dm_rdata;
    logic        dm_misalign;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        stall_if;
    logic        stall_mem;
`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_if_stall_cnt;
    logic [31:0] perf_dm_stall_cnt;
`endif

    int passed = 0;
    int failed = 0;
    int total  = 0;

    mem_arbiter #(.FETCH_STARVE_LIMIT(4), .ADDR_W(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .if_done     (if_done),
        .if_rdata    (if_rdata),
        .dm_req      (dm_req),
        .dm_we       (dm_we),
        .dm_funct3   (dm_funct3),
        .dm_addr     (dm_addr),
        .dm_wdata    (dm_wdata),
        .dm_done     (dm_done),
        .dm_rdata    (dm_rdata),
        .dm_misalign (dm_misalign),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_be      (mem_be),
        .mem_wdata   (mem_wdata),
        .mem_ready   (mem_ready),
        .mem_rdata   (mem_rdata),
        .stall_if    (stall_if),
`ifdef MEM_ARB_PERF_EN
        .stall_mem   (stall_mem),
        .perf_if_stall_cnt (perf_if_stall_cnt),
        .perf_dm_stall_cnt (perf_dm_stall_cnt)
`else
        .stall_mem   (stall_mem)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset asserted with a misaligned store pending: nothing may leak out.
        rst_n = 1'b1; if_req = 1'b0; if_addr = '0;
        dm_req = 1'b1; dm_we = 1'b1; dm_funct3 = 3'b010; dm_addr = 32'h102; dm_wdata = '0;
        mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_dm_done", dm_done, 0);
        chk("rst_misalign", dm_misalign, 0);
        chk("rst_dm_rdata", dm_rdata, 0);
        chk("rst_mem_be", mem_be, 0);
        chk("rst_if_done", if_done, 0);
`ifdef MEM_ARB_PERF_EN
        chk("rst_perf_if", perf_if_stall_cnt, 0);
        chk("rst_perf_dm", perf_dm_stall_cnt, 0);
`endif
        @(negedge clk); dm_req = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        #1 chk("post_rst_mem_req", mem_req, 0);

        // Fetch only, zero-wait memory.
        @(negedge clk); if_req = 1'b1; if_addr = 32'h40;
        #1;
        chk("f_c0_mem_req", mem_req, 0);
        chk("f_c0_stall_if", stall_if, 1);
        chk("f_c0_if_done", if_done, 0);
        @(negedge clk); #1;
        chk("f_c1_mem_req", mem_req, 1);
        chk("f_c1_mem_addr", mem_addr, 32'h40);
        chk("f_c1_mem_we", mem_we, 0);
        chk("f_c1_mem_be", mem_be, 4'hF);
        chk("f_c1_if_done", if_done, 1);
        chk("f_c1_if_rdata", if_rdata, 32'h1234_5678);
        chk("f_c1_stall_if", stall_if, 0);
        @(negedge clk); if_req = 1'b0;
        #1;
        chk("f_c2_mem_req", mem_req, 0);
        chk("f_c2_if_done", if_done, 0);

        // Simultaneous requests, data wins, two wait states.
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h80;
        dm_req = 1'b1; dm_we = 1'b0; dm_funct3 = 3'b010; dm_addr = 32'h100;
        mem_ready = 1'b0; mem_rdata = 32'hCAFE_F00D;
        #1;
        chk("s_c0_mem_req", mem_req, 0);
        chk("s_c0_stall_if", stall_if, 1);
        chk("s_c0_stall_mem", stall_mem, 1);
        @(negedge clk); #1;
        chk("s_c1_mem_req", mem_req, 1);
        chk("s_c1_mem_addr", mem_addr, 32'h100);
        chk("s_c1_mem_we", mem_we, 0);
        chk("s_c1_dm_done", dm_done, 0);
        chk("s_c1_if_done", if_done, 0);
        @(negedge clk); #1;
        chk("s_c2_dm_done", dm_done, 0);
        chk("s_c2_stall_mem", stall_mem, 1);
        chk("s_c2_stall_if", stall_if, 1);
        @(negedge clk); mem_ready = 1'b1;
        #1;
        chk("s_c3_dm_done", dm_done, 1);
        chk("s_c3_dm_rdata", dm_rdata, 32'hCAFE_F00D);
        chk("s_c3_misalign", dm_misalign, 0);
        chk("s_c3_stall_mem", stall_mem, 0);
        chk("s_c3_stall_if", stall_if, 1);
        @(negedge clk); dm_req = 1'b0;
        #1;
        chk("s_c4_mem_req", mem_req, 0);
        chk("s_c4_stall_if", stall_if, 1);
        @(negedge clk); #1;
        chk("s_c5_mem_addr", mem_addr, 32'h80);
        chk("s_c5_if_done", if_done, 1);
        chk("s_c5_if_rdata", if_rdata, 32'hCAFE_F00D);
        chk("s_c5_dm_done", dm_done, 0);
        chk("s_c5_mem_we", mem_we, 0);

        // Byte and half stores: lane enables and replicated data.
        @(negedge clk);
        if_req = 1'b0;
        dm_req = 1'b1; dm_we = 1'b1; dm_funct3 = 3'b000; dm_addr = 32'h103; dm_wdata = 32'h0000_00A5;
        #1 chk("sb_c0_mem_req", mem_req, 0);
        @(negedge clk); #1;
        chk("sb_mem_be", mem_be, 4'b1000);
        chk("sb_mem_wdata", mem_wdata, 32'hA5A5_A5A5);
        chk("sb_mem_addr", mem_addr, 32'h100);
        chk("sb_mem_we", mem_we, 1);
        chk("sb_dm_done", dm_done, 1);
        @(negedge clk); dm_funct3 = 3'b001; dm_addr = 32'h102; dm_wdata = 32'h0000_BEEF;
        #1 chk("sh_c0_mem_req", mem_req, 0);
        @(negedge clk); #1;
        chk("sh_mem_be", mem_be, 4'b1100);
        chk("sh_mem_wdata", mem_wdata, 32'hBEEF_BEEF);
        chk("sh_mem_addr", mem_addr, 32'h100);
        chk("sh_dm_done", dm_done, 1);

        // Misaligned word store and half load abort in IDLE; an aligned byte load is served.
        @(negedge clk); dm_funct3 = 3'b010; dm_addr = 32'h102;
        #1;
        chk("sw_mis_done", dm_done, 1);
        chk("sw_mis_flag", dm_misalign, 1);
        chk("sw_mis_mem_req", mem_req, 0);
        chk("sw_mis_stall_mem", stall_mem, 0);
        @(negedge clk); dm_we = 1'b0; dm_funct3 = 3'b101; dm_addr = 32'h101;
        #1;
        chk("lh_mis_flag", dm_misalign, 1);
        chk("lh_mis_done", dm_done, 1);
        chk("lh_mis_mem_req", mem_req, 0);
        @(negedge clk); dm_funct3 = 3'b100; dm_addr = 32'h103;
        #1;
        chk("lbu_c0_misalign", dm_misalign, 0);
        chk("lbu_c0_done", dm_done, 0);
        @(negedge clk); #1;
        chk("lbu_mem_be", mem_be, 4'b1000);
        chk("lbu_mem_we", mem_we, 0);
        chk("lbu_done", dm_done, 1);
        chk("lbu_misalign", dm_misalign, 0);

        // Starvation: four data grants, then fetch must win, then data again.
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h200;
        dm_req = 1'b1; dm_we = 1'b0; dm_funct3 = 3'b010; dm_addr = 32'h300;
        mem_rdata = 32'h1111_2222;
        for (int i = 0; i < 4; i++) begin
            #1 chk($sformatf("stv_idle%0d_mem_req", i), mem_req, 0);
            @(negedge clk); #1;
            chk($sformatf("stv_grant%0d_dm_done", i), dm_done, 1);
            chk($sformatf("stv_grant%0d_if_done", i), if_done, 0);
            @(negedge clk);
        end
        #1 chk("stv_idle4_mem_req", mem_req, 0);
        @(negedge clk); #1;
        chk("stv_fetch_if_done", if_done, 1);
        chk("stv_fetch_dm_done", dm_done, 0);
        chk("stv_fetch_mem_addr", mem_addr, 32'h200);
        @(negedge clk); #1 chk("stv_idle5_mem_req", mem_req, 0);
        @(negedge clk); #1;
        chk("stv_after_dm_done", dm_done, 1);
        chk("stv_after_mem_addr", mem_addr, 32'h300);

        // Reset pulse between edges in the middle of a data access.
        @(negedge clk);
        if_req = 1'b0;
        dm_addr = 32'h400; mem_ready = 1'b0;
        #1 chk("ar_c0_mem_req", mem_req, 0);
        @(negedge clk); #1;
        chk("ar_c1_mem_req", mem_req, 1);
        chk("ar_c1_mem_addr", mem_addr, 32'h400);
        #1 rst_n = 1'b0;
        #1;
        chk("ar_low_mem_req", mem_req, 0);
        chk("ar_low_mem_addr", mem_addr, 0);
        chk("ar_low_dm_done", dm_done, 0);
        dm_req = 1'b0;
        #1 rst_n = 1'b1;
        @(negedge clk); #1;
        chk("ar_post_mem_req", mem_req, 0);
        chk("ar_post_dm_done", dm_done, 0);
`ifdef MEM_ARB_PERF_EN
        chk("ar_post_perf_if", perf_if_stall_cnt, 0);
        chk("ar_post_perf_dm", perf_dm_stall_cnt, 0);
`endif
        @(negedge clk); if_req = 1'b1; if_addr = 32'h4; mem_ready = 1'b1;
        @(negedge clk); #1;
        chk("ar_fetch_if_done", if_done, 1);
        chk("ar_fetch_mem_addr", mem_addr, 32'h4);
        @(negedge clk); if_req = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
